// File: rtl/irq_vector_ctrl.sv
// Vectored IRQ controller: edge-latched pending bits, enable mask, fixed priority.
// Define IRQ_NESTED_EN to let higher-priority channels preempt a running handler.
module irq_vector_ctrl #(
  parameter int unsigned   NCH       = 4,
  parameter logic [31:0]   BASE_ADDR = 32'h4000_0100,
  parameter logic [31:0]   VEC_BASE  = 32'h8000_0020,
  parameter logic [NCH-1:0] EN_RST   = {NCH{1'b1}}
) (
  input  logic           reset,
  input  logic           myclk,
  input  logic [NCH-1:0] irq_in,
  input  logic           monin,
  input  logic           rd,
  input  logic           wr,
  input  logic [31:0]    addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic           irq_req,
  output logic [31:0]    irq_vec,
  input  logic           irq_ack,
  input  logic           eret
);

  localparam int unsigned WW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [31:0] A_EN   = BASE_ADDR;
  localparam logic [31:0] A_PEND = BASE_ADDR + 32'h4;
  localparam logic [31:0] A_ISV  = BASE_ADDR + 32'h8;

  logic [NCH-1:0] irq_in_d;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] inservice;

  logic [NCH-1:0] rise;
  logic [NCH-1:0] cand;
  logic [NCH-1:0] win_oh;
  logic [WW-1:0]  win_idx;
  logic [NCH-1:0] isv_low;
  logic           gate;
  logic           ack_fire;

  logic           sel_en;
  logic           sel_pend;
  logic           sel_isv;
  logic           en_we;
  logic           pend_we;

  logic [NCH-1:0] ack_oh;
  logic [NCH-1:0] w1c;
  logic [NCH-1:0] ret_oh;
  logic [NCH-1:0] pend_nxt;
  logic [NCH-1:0] isv_nxt;
  logic [NCH-1:0] rsel;

  logic           unused_wdata;

  assign unused_wdata = ^wdata[31:NCH];

  assign rise = irq_in & ~irq_in_d;
  assign cand = pending & enable;

  // Isolate lowest set bit: channel 0 wins.
  assign win_oh  = cand & (~cand + {{(NCH-1){1'b0}}, 1'b1});
  assign isv_low = inservice & (~inservice + {{(NCH-1){1'b0}}, 1'b1});

  always_comb begin
    win_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx = WW'(i);
      end
    end
  end

`ifdef IRQ_NESTED_EN
  logic [WW-1:0] isv_idx;

  always_comb begin
    isv_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (inservice[i]) begin
        isv_idx = WW'(i);
      end
    end
  end

  assign gate = (inservice == '0) ||
                (win_idx < isv_idx);
`else
  assign gate = (inservice == '0);
`endif

  assign irq_req = (cand != '0) & ~monin & gate;

  assign irq_vec = VEC_BASE +
                   {{(30-WW){1'b0}}, win_idx, 2'b00};

  assign ack_fire = irq_ack & irq_req;

  assign sel_en   = (addr == A_EN);
  assign sel_pend = (addr == A_PEND);
  assign sel_isv  = (addr == A_ISV);

  assign en_we   = wr & sel_en;
  assign pend_we = wr & sel_pend;

  // A fresh edge outranks any clear in the same cycle.
  always_comb begin
    ack_oh   = ack_fire ? win_oh : '0;
    w1c      = pend_we ? wdata[NCH-1:0] : '0;
    ret_oh   = eret ? isv_low : '0;
    pend_nxt = (pending & ~(ack_oh | w1c)) | rise;
    isv_nxt  = (inservice & ~ret_oh) | ack_oh;
  end

  always_comb begin
    rsel = '0;
    unique case (1'b1)
      sel_en:   rsel = enable;
      sel_pend: rsel = pending;
      sel_isv:  rsel = inservice;
      default:  rsel = '0;
    endcase
  end

  generate
    if (NCH < 32) begin : g_pad
      assign rdata = rd ? {{(32-NCH){1'b0}}, rsel} : 32'h0;
    end else begin : g_full
      assign rdata = rd ? 32'(rsel) : 32'h0;
    end
  endgenerate

  always_ff @(posedge myclk or posedge reset) begin
    if (reset) begin
      irq_in_d  <= '0;
      pending   <= '0;
      inservice <= '0;
      enable    <= EN_RST;
    end else begin
      irq_in_d  <= irq_in;
      pending   <= pend_nxt;
      inservice <= isv_nxt;
      if (en_we) begin
        enable <= wdata[NCH-1:0];
      end
    end
  end

endmodule
